// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: opcodes, FSM encoding, widths and the
// decode-stage source-register payload used by the hazard compare.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned RS_USED_W  = 2;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned WAIT_W     = 16;
    localparam int unsigned STATE_W    = 2;
    localparam int unsigned INSTR_W    = 32;

    localparam logic [OPCODE_W-1:0] OPC_LOAD = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_JAL  = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_NOP  = 7'b0010011;
    localparam logic [INSTR_W-1:0]  NOP_INSTR = 32'h0000_0013;

    localparam logic [STATE_W-1:0] RUN      = 2'd0;
    localparam logic [STATE_W-1:0] MEM_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ERROR    = 2'd2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr_rs1;
        logic [REG_ADDR_W-1:0] addr_rs2;
        logic [RS_USED_W-1:0]  rs_used;
    } decode_src_t;

    function automatic logic is_load(input logic [OPCODE_W-1:0] opcode);
        return opcode == OPC_LOAD;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its hazard/stall controller.
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] addr_rs1_d;
    logic [REG_ADDR_W-1:0] addr_rs2_d;
    logic [RS_USED_W-1:0]  rs_used_d;
    logic [OPCODE_W-1:0]   opcode_x;
    logic [REG_ADDR_W-1:0] rd_x;
    logic                  br_taken_x;
    logic                  dmem_req_m;
    logic                  dmem_ready_m;

    logic                  stall;
    logic                  stall_xm;
    logic                  kill_dx;
    logic                  bubble_x;
    logic                  pc_redirect;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output addr_rs1_d, addr_rs2_d, rs_used_d, opcode_x, rd_x,
               br_taken_x, dmem_req_m, dmem_ready_m,
        input  stall, stall_xm, kill_dx, bubble_x, pc_redirect,
               mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  addr_rs1_d, addr_rs2_d, rs_used_d, opcode_x, rd_x,
               br_taken_x, dmem_req_m, dmem_ready_m,
        output stall, stall_xm, kill_dx, bubble_x, pc_redirect,
               mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in execute writing a register that the
// instruction in decode actually reads.
module pipeline_ctrl_hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  decode_src_t           i_src,
    input  logic [OPCODE_W-1:0]   i_opcode_x,
    input  logic [REG_ADDR_W-1:0] i_rd_x,
    output logic                  o_load_use_c
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    always_comb begin
        w_rs1_hit    = i_src.rs_used[0] && (i_src.addr_rs1 == i_rd_x);
        w_rs2_hit    = i_src.rs_used[1] && (i_src.addr_rs2 == i_rd_x);
        // x0 is never written, so a load targeting it cannot create a hazard
        o_load_use_c = is_load(i_opcode_x) && (i_rd_x != '0) && (w_rs1_hit || w_rs2_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, branch flush,
// load-use interlock and saturating stall/flush event counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
)
(
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_next;
    logic [WAIT_W-1:0]  w_wait_inc;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    decode_src_t w_src;
    logic        w_load_use;
    logic        w_mem_block;
    logic        w_stall;
    logic        w_stall_xm;
    logic        w_kill_dx;
    logic        w_bubble_x;
    logic        w_pc_redirect;

    assign w_src = '{addr_rs1: bus.addr_rs1_d,
                     addr_rs2: bus.addr_rs2_d,
                     rs_used:  bus.rs_used_d};

    pipeline_ctrl_hazard_detect u_hazard_detect (
        .i_src        (w_src),
        .i_opcode_x   (bus.opcode_x),
        .i_rd_x       (bus.rd_x),
        .o_load_use_c (w_load_use)
    );

    assign w_mem_block = bus.dmem_req_m && !bus.dmem_ready_m;
    assign w_wait_inc  = r_wait_cnt + WAIT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    // Next state and stall/flush decode; memory block outranks branch outranks load-use
    always_comb begin
        w_state_next  = r_state;
        w_wait_next   = r_wait_cnt;
        w_stall       = 1'b0;
        w_stall_xm    = 1'b0;
        w_kill_dx     = 1'b0;
        w_bubble_x    = 1'b0;
        w_pc_redirect = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_block) begin
                    w_stall      = 1'b1;
                    w_stall_xm   = 1'b1;
                    w_state_next = MEM_WAIT;
                    w_wait_next  = '0;
                end else if (bus.br_taken_x) begin
                    w_kill_dx     = 1'b1;
                    w_bubble_x    = 1'b1;
                    w_pc_redirect = 1'b1;
                end else if (w_load_use) begin
                    w_stall    = 1'b1;
                    w_bubble_x = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Whole pipe stays frozen on the completion cycle; a pending branch is taken next cycle
                w_stall    = 1'b1;
                w_stall_xm = 1'b1;
                if (bus.dmem_ready_m) begin
                    w_state_next = RUN;
                end else begin
                    w_wait_next = w_wait_inc;
                    if (w_wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                        w_state_next = ERROR;
                    end
                end
            end
            ERROR: begin
                w_stall    = 1'b1;
                w_stall_xm = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_pc_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall       = w_stall;
    assign bus.stall_xm    = w_stall_xm;
    assign bus.kill_dx     = w_kill_dx;
    assign bus.bubble_x    = w_bubble_x;
    assign bus.pc_redirect = w_pc_redirect;
    assign bus.mem_timeout = (r_state == ERROR);
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: single-cycle hazard table plus hand-written
// memory-wait, timeout and reset sequences.
module tb_pipeline_ctrl;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  used;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic        br;
        logic        req;
        logic        rdy;
        logic        e_stall;
        logic        e_kill;
        logic        e_bubble;
        logic        e_redir;
        logic [31:0] e_sc;
        logic [31:0] e_fc;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t vecs[13];

    pipeline_ctrl_if u_if ();

    pipeline_ctrl #(.MEM_TIMEOUT(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [1:0] used, input logic [6:0] opc,
                                input logic [4:0] rd, input logic br, input logic req,
                                input logic rdy, input logic s, input logic k,
                                input logic b, input logic r,
                                input logic [31:0] sc, input logic [31:0] fc);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.used = used; v.opc = opc; v.rd = rd;
        v.br = br; v.req = req; v.rdy = rdy;
        v.e_stall = s; v.e_kill = k; v.e_bubble = b; v.e_redir = r;
        v.e_sc = sc; v.e_fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic s, input logic sx,
                           input logic k, input logic b, input logic r, input logic t);
        chk({tag, ".stall"},       32'(u_if.stall), 32'(s));
        chk({tag, ".stall_xm"},    32'(u_if.stall_xm), 32'(sx));
        chk({tag, ".kill_dx"},     32'(u_if.kill_dx), 32'(k));
        chk({tag, ".bubble_x"},    32'(u_if.bubble_x), 32'(b));
        chk({tag, ".pc_redirect"}, 32'(u_if.pc_redirect), 32'(r));
        chk({tag, ".mem_timeout"}, 32'(u_if.mem_timeout), 32'(t));
        chk({tag, ".stall_and_kill"}, 32'(u_if.stall & u_if.kill_dx), 32'd0);
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] sc, input logic [31:0] fc);
        chk({tag, ".stall_cnt"}, u_if.stall_cnt, sc);
        chk({tag, ".flush_cnt"}, u_if.flush_cnt, fc);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used,
                         input logic [6:0] opc, input logic [4:0] rd, input logic br,
                         input logic req, input logic rdy);
        u_if.addr_rs1_d   = rs1;
        u_if.addr_rs2_d   = rs2;
        u_if.rs_used_d    = used;
        u_if.opcode_x     = opc;
        u_if.rd_x         = rd;
        u_if.br_taken_x   = br;
        u_if.dmem_req_m   = req;
        u_if.dmem_ready_m = rdy;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked while still asserted
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        drive(5'd0, 5'd0, 2'b00, OP_ALU, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt(tag, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(5'd0, 5'd0, 2'b00, OP_ALU, 5'd0, 1'b0, 1'b0, 1'b0);

        //          rs1    rs2    used   opc      rd     br    req   rdy   stl   kill  bub   redir  sc     fc
        vecs[0]  = mk(5'd0,  5'd0,  2'b00, OP_ALU,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        vecs[1]  = mk(5'd5,  5'd0,  2'b01, OP_LOAD, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
        vecs[2]  = mk(5'd0,  5'd0,  2'b01, OP_LOAD, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0);
        vecs[3]  = mk(5'd5,  5'd0,  2'b00, OP_LOAD, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0);
        vecs[4]  = mk(5'd0,  5'd7,  2'b10, OP_LOAD, 5'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 32'd0);
        vecs[5]  = mk(5'd3,  5'd7,  2'b01, OP_LOAD, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd0);
        vecs[6]  = mk(5'd5,  5'd0,  2'b01, OP_ALU,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd0);
        vecs[7]  = mk(5'd5,  5'd0,  2'b01, OP_LOAD, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2, 32'd1);
        vecs[8]  = mk(5'd0,  5'd0,  2'b00, OP_ALU,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2, 32'd2);
        vecs[9]  = mk(5'd5,  5'd0,  2'b01, OP_LOAD, 5'd5,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd2);
        vecs[10] = mk(5'd0,  5'd0,  2'b00, OP_ALU,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 32'd3);
        vecs[11] = mk(5'd4,  5'd9,  2'b11, OP_LOAD, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4, 32'd3);
        vecs[12] = mk(5'd31, 5'd31, 2'b11, OP_LOAD, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'd3);

        // Reset state while rst_n is held low
        #12;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("reset", 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle RUN-state table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].used, vecs[i].opc, vecs[i].rd,
                  vecs[i].br, vecs[i].req, vecs[i].rdy);
            #1;
            chk_out($sformatf("row%0d", i), vecs[i].e_stall, 1'b0, vecs[i].e_kill,
                    vecs[i].e_bubble, vecs[i].e_redir, 1'b0);
            edge_settle();
            chk_cnt($sformatf("row%0d", i), vecs[i].e_sc, vecs[i].e_fc);
        end

        // Memory wait of three stalled cycles; branch held during it is taken afterwards
        pulse_reset("rst_a");
        @(negedge clk);
        drive(5'd0, 5'd0, 2'b00, OP_ALU, 5'd0, 1'b1, 1'b1, 1'b0);
        #1;
        chk_out("memA_c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_settle();
        @(negedge clk);
        #1;
        chk_out("memA_c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_settle();
        @(negedge clk);
        u_if.dmem_ready_m = 1'b1;
        #1;
        chk_out("memA_ready", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_settle();
        chk_cnt("memA_ready", 32'd3, 32'd0);
        @(negedge clk);
        u_if.dmem_req_m   = 1'b0;
        u_if.dmem_ready_m = 1'b0;
        #1;
        chk_out("memA_branch", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        edge_settle();
        chk_cnt("memA_branch", 32'd3, 32'd1);

        // Timeout with MEM_TIMEOUT=4: one RUN block cycle plus four MEM_WAIT cycles
        pulse_reset("rst_b");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 2'b00, OP_ALU, 5'd0, 1'b0, 1'b1, 1'b0);
            #1;
            chk_out($sformatf("tmo_wait%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            edge_settle();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(5'd5, 5'd0, 2'b01, OP_LOAD, 5'd5, 1'b1, 1'b1, 1'b1);
            #1;
            chk_out($sformatf("tmo_err%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            edge_settle();
        end
        chk_cnt("tmo_err", 32'd7, 32'd0);
        pulse_reset("rst_err");
        @(negedge clk);
        drive(5'd0, 5'd0, 2'b00, OP_ALU, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk_out("post_err_run", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        edge_settle();
        chk_cnt("post_err_run", 32'd0, 32'd1);

        // Reset landing in MEM_WAIT; request dropped but state still holds the pipe
        pulse_reset("rst_c");
        @(negedge clk);
        drive(5'd0, 5'd0, 2'b00, OP_ALU, 5'd0, 1'b0, 1'b1, 1'b0);
        edge_settle();
        @(negedge clk);
        drive(5'd0, 5'd0, 2'b00, OP_ALU, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_out("memC_wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_reset("rst_mid_wait");
        @(negedge clk);
        #1;
        chk_out("memC_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_settle();
        chk_cnt("memC_run", 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
